shift_add_mult: RTL and testbench
=================================

Name: shift_add_mult

Overview:
- Sequential unsigned shift-and-add multiplier.
- Directly consumes the left-shift operation: each iteration shifts the multiplicand left by one and conditionally accumulates it.
- Sits downstream of the shift stage in the arithmetic datapath; gives the catalog a multi-cycle multiply with a start/busy/done handshake.
- Fixed latency of n iterations per operation.

Parameters:
- n, 8, operand width in bits; product is 2n bits. Legal n >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- a  input  n  multiplicand, unsigned; sampled on the accepting edge only
- b  input  n  multiplier, unsigned; sampled on the accepting edge only
- busy  output  1  high while state is RUN or DONE
- done  output  1  one-cycle pulse: product valid for the new result
- product  output  2n  result register; holds the last result until the next result is written

Behaviour:
- Reset (rst=0, asynchronous, at any time including mid-operation):
  - state=IDLE, busy=0, done=0, product=0.
  - Internal mcand, mplier, acc and count cleared.
  - The operation in flight is discarded.
  - Operation resumes on the first rising clk edge after rst returns to 1.
- Internal registers:
  - mcand (2n bits, a zero-extended)
  - mplier (n bits)
  - acc (2n bits)
  - count (clog2(n+1) bits)
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1 at an edge (call it E0): mcand<=zero-extended a, mplier<=b, acc<=0, count<=0, state<=RUN.
  - Otherwise remain in IDLE.
- RUN, at each edge:
  - acc <= acc + (mplier[0] ? mcand : 0), computed modulo 2^2n (no overflow is possible).
  - mcand <= mcand << 1 (logical, zero fill).
  - mplier <= mplier >> 1 (logical).
  - count <= count+1.
  - On the edge where count==n-1 (the nth iteration, edge En): product <= final acc value including that iteration's add; state<=DONE.
- DONE:
  - done=1 for exactly this one cycle (between En and En+1).
  - Next edge: state<=IDLE.
- Outputs:
  - busy and done are registered-state decodes: busy=(state!=IDLE), done=(state==DONE).
  - Neither has a combinational path from start.
- Latency: done is high in the cycle following En, i.e. n edges after the accepting edge E0.
- Throughput: one result per n+2 cycles. A new start is accepted at the earliest in the IDLE cycle after DONE.
- start while busy=1 (RUN or DONE): ignored; no effect on the operation or its result.
- a and b may change freely after E0; the result depends only on values captured at E0.
- product changes only at En; it is stable during IDLE, RUN and DONE otherwise.
- Boundary cases:
  - a=0 or b=0: product=0.
  - a=b=2^n-1: product=(2^n-1)^2, which fits in 2n bits.
- start held continuously high: back-to-back operations, each accepted in the IDLE cycle after DONE.

Test Plan:
- n=8, reset then start with a=13, b=11 for one cycle:
  - busy=1 from the next cycle.
  - done pulses exactly 8 edges after the accepting edge.
  - product=143 and held afterward; busy=0 one cycle after done.
- a=255, b=255 -> product=65025 (0xFE01); a=0, b=200 -> product=0; a=1, b=1 -> product=1. Each with done after 8 edges.
- Start with a=7, b=6; pulse start=1 with a=3, b=3 during RUN and again during DONE -> product=42; the second request is never executed; no extra done.
- Hold start=1 with a=2, b=5, then change a/b to 4/4 after the first accept:
  - first result 10, second result 16.
  - done pulses exactly 10 cycles apart.
- Start with a=9, b=9; drive rst=0 asynchronously between clock edges 4 edges in:
  - busy, done and product go to 0 immediately, without waiting for an edge.
  - After release, a new start with a=3, b=5 yields product=15 with normal latency.
- Random a/b sweep (>=1000 ops, n=8 and n=16) checking the product against a*b:
  - product unchanged except at the done transition.
  - busy never drops between accept and done.

Source files
------------

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock,
// n iterations per operation, product held in a result register until the next result.
module shift_add_mult #(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*n-1:0] product,
  output logic [1:0]     dbg_state
);

  // Handshake: start is sampled only while busy=0 (IDLE); the accepting edge
  // captures a/b. busy stays high through RUN and DONE, during which start is
  // ignored. done is a one-cycle pulse marking product as the new result.

  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] LAST = CW'(n - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [2*n-1:0]   mcand_q;
  logic [n-1:0]     mplier_q;
  logic [2*n-1:0]   acc_q;
  logic [2*n-1:0]   acc_d;
  logic [2*n-1:0]   product_q;
  logic [CW-1:0]    count_q;
  logic             busy_q;
  logic             done_q;

  // Accumulator next value; cannot overflow since the final sum is < 2^(2n).
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mcand_q  <= {{n{1'b0}}, a};
            mplier_q <= b;
            acc_q    <= '0;
            count_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CW'(1);
          if (count_q == LAST) begin
            product_q <= acc_d;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign product   = product_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Directed and random checks of shift_add_mult at n=8 and n=16: latency,
// hold behaviour, ignored starts, back-to-back operation and async reset.
module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic        busy8, done8;
  logic [15:0] product8;
  logic [1:0]  st8;
  logic        start16 = 1'b0;
  logic [15:0] a16 = '0;
  logic [15:0] b16 = '0;
  logic        busy16, done16;
  logic [31:0] product16;
  logic [1:0]  st16;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shift_add_mult #(.n(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(product8), .dbg_state(st8)
  );

  shift_add_mult #(.n(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .product(product16), .dbg_state(st16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Called #1 after the accepting edge; returns the number of edges until done.
  task automatic wait_done8(output int edges);
    logic [15:0] p0;
    p0 = product8;
    edges = 0;
    while (!done8 && edges < 40) begin
      chk("busy8_run", busy8, 1);
      chk("hold8_run", product8, p0);
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic wait_done16(output int edges);
    logic [31:0] p0;
    p0 = product16;
    edges = 0;
    while (!done16 && edges < 60) begin
      chk("busy16_run", busy16, 1);
      chk("hold16_run", product16, p0);
      @(posedge clk); #1;
      edges++;
    end
  endtask

  // driver: one-cycle start pulse, then scramble a/b to prove they were captured
  task automatic op8(input logic [7:0] av, input logic [7:0] bv, input string tag);
    int e;
    exp_q.push_back(32'(av) * 32'(bv));
    @(posedge clk); #1;
    start8 = 1'b1; a8 = av; b8 = bv;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    wait_done8(e);
    chk({tag, "_lat"}, e, 8);
    chk({tag, "_prod"}, product8, exp_q.pop_front());
    @(posedge clk); #1;
    chk({tag, "_done_clr"}, done8, 0);
    chk({tag, "_busy_clr"}, busy8, 0);
    chk({tag, "_held"}, product8, 32'(av) * 32'(bv));
  endtask

  task automatic op16(input logic [15:0] av, input logic [15:0] bv);
    int e;
    exp_q.push_back(32'(av) * 32'(bv));
    @(posedge clk); #1;
    start16 = 1'b1; a16 = av; b16 = bv;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    wait_done16(e);
    chk("r16_lat", e, 16);
    chk("r16_prod", product16, exp_q.pop_front());
    @(posedge clk); #1;
    chk("r16_busy_clr", busy16, 0);
  endtask

  initial begin
    int e, nd, d1, d2;

    // reset state
    #12;
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_prod8", product8, 0);
    chk("rst_state8", st8, 0);
    chk("rst_busy16", busy16, 0);
    chk("rst_prod16", product16, 0);
    @(negedge clk); rst = 1'b1;

    // basic and boundary products
    op8(8'd13, 8'd11, "m13x11");
    op8(8'd255, 8'd255, "m255x255");
    op8(8'd0, 8'd200, "m0x200");
    op8(8'd1, 8'd1, "m1x1");
    op8(8'd200, 8'd0, "m200x0");

    // start pulses during RUN and DONE are ignored
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'd7; b8 = 8'd6;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("ign_state_run", st8, 1);
    repeat (2) begin @(posedge clk); #1; end
    start8 = 1'b1; a8 = 8'd3; b8 = 8'd3;
    @(posedge clk); #1;
    start8 = 1'b0;
    wait_done8(e);
    chk("ign_lat", 3 + e, 8);
    chk("ign_prod", product8, 42);
    start8 = 1'b1; a8 = 8'd3; b8 = 8'd3;
    @(posedge clk); #1;
    start8 = 1'b0;
    nd = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done8 || busy8) nd++;
    end
    chk("ign_no_extra", nd, 0);
    chk("ign_prod_held", product8, 42);

    // start held high: back-to-back, inputs changed after first accept
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'd2; b8 = 8'd5;
    @(posedge clk); #1;
    a8 = 8'd4; b8 = 8'd4;
    wait_done8(e);
    d1 = cyc;
    chk("b2b_lat1", e, 8);
    chk("b2b_prod1", product8, 10);
    @(posedge clk); #1;
    chk("b2b_idle", busy8, 0);
    @(posedge clk); #1;
    wait_done8(e);
    d2 = cyc;
    start8 = 1'b0;
    chk("b2b_lat2", e, 8);
    chk("b2b_prod2", product8, 16);
    chk("b2b_spacing", d2 - d1, 10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("b2b_stop", busy8, 0);

    // asynchronous reset mid-operation, between edges
    @(posedge clk); #1;
    start8 = 1'b1; a8 = 8'd9; b8 = 8'd9;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_busy", busy8, 0);
    chk("arst_done", done8, 0);
    chk("arst_prod", product8, 0);
    chk("arst_state", st8, 0);
    @(negedge clk); rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("arst_quiet", busy8, 0);
    op8(8'd3, 8'd5, "m3x5");

    // random sweep
    for (int i = 0; i < 1000; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      op8(ra, rb, "r8");
    end
    op16(16'hFFFF, 16'hFFFF);
    op16(16'd0, 16'd1234);
    for (int i = 0; i < 1000; i++) begin
      op16(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    end

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
